sram_arbiter_2p: RTL and testbench

Two-requester round-robin arbiter and sequencer for the `IHP_SRAM_1024x32` fabric primitive. It lets two user-design masters share one SRAM macro, for example a soft CPU and a DMA/UART loader. Each master uses a valid/ready request handshake and gets back a tagged read response. The block sits between the user logic and `IHP_SRAM_1024x32_wrapper`, and drives that wrapper's ADDR/BM/DIN/WEN/MEN/REN pins directly.

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 41 ++++
 rtl/sram_arbiter_2p.sv | 90 +++++++++
 tb/tb_sram_arbiter_2p.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants, types and helpers for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int NUM_REQ    = 2;
  localparam int MAX_RD_LAT = 2;

  typedef logic req_id_t;

  function automatic logic [31:0] be_to_bm(input logic [3:0] be);
    logic [31:0] bm;
    for (int k = 0; k < 4; k++) begin
      bm[8*k +: 8] = {8{be[k]}};
    end
    return bm;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with per-requester lock; grant is combinational,
// the priority pointer is registered.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [NUM_REQ-1:0] i_lock,
  output logic [NUM_REQ-1:0] o_grant,
  output req_id_t            o_prio
);

  req_id_t r_prio;

  always_comb begin
    o_grant = '0;
    if (!i_rst) begin
      case (i_valid)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = r_prio ? 2'b10 : 2'b01;
        default: o_grant = 2'b00;
      endcase
    end
  end

  // A locked winner keeps the pointer; an unlocked winner hands it over.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prio <= 1'b0;
    end else if (o_grant[0]) begin
      r_prio <= ~i_lock[0];
    end else if (o_grant[1]) begin
      r_prio <= i_lock[1];
    end
  end

  assign o_prio = r_prio;

endmodule

// File: rtl/sram_arbiter_2p.sv
// Shares one IHP_SRAM_1024x32 macro between two valid/ready masters; requests
// reach the SRAM pins in the grant cycle, read data returns tagged RD_LAT cycles later.
module sram_arbiter_2p
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_REQ-1:0]        REQ_VALID,
  output logic [NUM_REQ-1:0]        REQ_READY,
  input  logic [NUM_REQ-1:0]        REQ_LOCK,
  input  logic [NUM_REQ-1:0]        REQ_WE,
  input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
  input  logic [NUM_REQ*32-1:0]     REQ_WDATA,
  input  logic [NUM_REQ*4-1:0]      REQ_BE,
  output logic [NUM_REQ-1:0]        RSP_VALID,
  output logic [31:0]               RSP_RDATA,
  output logic [ADDR_W-1:0]         SRAM_ADDR,
  output logic [31:0]               SRAM_DIN,
  output logic [31:0]               SRAM_BM,
  output logic                      SRAM_WEN,
  output logic                      SRAM_REN,
  output logic                      SRAM_MEN,
  input  logic [31:0]               SRAM_DOUT
);

  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
    $error("sram_arbiter_2p: RD_LAT must be 1 or 2");
  end

  logic [NUM_REQ-1:0] w_grant;
  req_id_t            w_prio_unused;
  req_id_t            w_gid;
  logic               w_any;
  logic               w_we;
  logic               w_rsp_vld;

  rr_arb2 u_arb (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_valid (REQ_VALID),
    .i_lock  (REQ_LOCK),
    .o_grant (w_grant),
    .o_prio  (w_prio_unused)
  );

  assign w_gid     = w_grant[1];
  assign w_any     = |w_grant;
  assign w_we      = REQ_WE[w_gid];
  assign REQ_READY = w_grant;
  assign SRAM_MEN  = w_any;
  assign SRAM_WEN  = w_any & w_we;
  assign SRAM_REN  = w_any & ~w_we;

  always_comb begin
    SRAM_ADDR = '0;
    SRAM_DIN  = '0;
    SRAM_BM   = '0;
    if (w_any) begin
      SRAM_ADDR = w_gid ? REQ_ADDR[2*ADDR_W-1:ADDR_W] : REQ_ADDR[ADDR_W-1:0];
      SRAM_DIN  = w_gid ? REQ_WDATA[63:32] : REQ_WDATA[31:0];
      SRAM_BM   = w_we ? be_to_bm(w_gid ? REQ_BE[7:4] : REQ_BE[3:0]) : '0;
    end
  end

  // Read-return pipe: stage RD_LAT-1 lines up with SRAM_DOUT.
  logic [RD_LAT-1:0] r_pipe_vld;
  logic [RD_LAT-1:0] r_pipe_id;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pipe_vld <= '0;
      r_pipe_id  <= '0;
    end else begin
      r_pipe_vld[0] <= w_any & ~w_we;
      r_pipe_id[0]  <= w_gid;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_id[i]  <= r_pipe_id[i-1];
      end
    end
  end

  assign w_rsp_vld = r_pipe_vld[RD_LAT-1] & ~RST;
  assign RSP_VALID = w_rsp_vld ? (r_pipe_id[RD_LAT-1] ? 2'b10 : 2'b01) : 2'b00;
  assign RSP_RDATA = w_rsp_vld ? SRAM_DOUT : '0;

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// Randomized + directed bench: RD_LAT=1 and RD_LAT=2 instances share stimulus and
// are compared each cycle against a queue/array reference model.
module tb_sram_arbiter_2p;

  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RST;
  logic [1:0]    REQ_VALID, REQ_LOCK, REQ_WE;
  logic [2*AW-1:0] REQ_ADDR;
  logic [63:0]   REQ_WDATA;
  logic [7:0]    REQ_BE;

  logic [1:0]    rdy1, rdy2, rspv1, rspv2;
  logic [31:0]   rd1, rd2;
  logic [AW-1:0] s1_addr, s2_addr;
  logic [31:0]   s1_din, s2_din, s1_bm, s2_bm;
  logic          s1_wen, s1_ren, s1_men, s2_wen, s2_ren, s2_men;
  logic [31:0]   dout1, dout2, dout2_q;

  logic [31:0]   mem1 [1024];
  logic [31:0]   mem2 [1024];
  logic [31:0]   ref_mem [1024];

  typedef struct {
    int          due;
    logic        id;
    logic [31:0] dat;
  } rsp_t;

  rsp_t q1[$];
  rsp_t q2[$];

  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  logic m_prio;
  logic [1:0]  obs_rdy, obs_rsp1, obs_rsp2;
  logic [31:0] obs_rd1, obs_bm1;
  logic        obs_wen1;

  always #5 CLK = ~CLK;

  sram_arbiter_2p #(.ADDR_W(AW), .RD_LAT(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(rdy1), .REQ_LOCK(REQ_LOCK),
    .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_BE(REQ_BE),
    .RSP_VALID(rspv1), .RSP_RDATA(rd1), .SRAM_ADDR(s1_addr), .SRAM_DIN(s1_din),
    .SRAM_BM(s1_bm), .SRAM_WEN(s1_wen), .SRAM_REN(s1_ren), .SRAM_MEN(s1_men),
    .SRAM_DOUT(dout1)
  );

  sram_arbiter_2p #(.ADDR_W(AW), .RD_LAT(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(rdy2), .REQ_LOCK(REQ_LOCK),
    .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_BE(REQ_BE),
    .RSP_VALID(rspv2), .RSP_RDATA(rd2), .SRAM_ADDR(s2_addr), .SRAM_DIN(s2_din),
    .SRAM_BM(s2_bm), .SRAM_WEN(s2_wen), .SRAM_REN(s2_ren), .SRAM_MEN(s2_men),
    .SRAM_DOUT(dout2)
  );

  // SRAM macros: one-cycle read, plus an extra fabric register for the RD_LAT=2 copy.
  always @(posedge CLK) begin
    if (s1_men && s1_ren) dout1 <= mem1[s1_addr];
    if (s1_men && s1_wen) mem1[s1_addr] <= (mem1[s1_addr] & ~s1_bm) | (s1_din & s1_bm);
    if (s2_men && s2_ren) dout2_q <= mem2[s2_addr];
    dout2 <= dout2_q;
    if (s2_men && s2_wen) mem2[s2_addr] <= (mem2[s2_addr] & ~s2_bm) | (s2_din & s2_bm);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] expand(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic set_req(input logic [1:0] v, input logic [1:0] lk, input logic [1:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [3:0] b0, input logic [3:0] b1);
    REQ_VALID = v;
    REQ_LOCK  = lk;
    REQ_WE    = we;
    REQ_ADDR  = {a1, a0};
    REQ_WDATA = {d1, d0};
    REQ_BE    = {b1, b0};
  endtask

  // One clock cycle: check outputs at the falling edge, then advance the model.
  task automatic cyc_step();
    logic [1:0]    eg, ev1, ev2;
    logic          gi, ew;
    logic [AW-1:0] ea;
    logic [31:0]   ed, ebm, edat1, edat2;
    logic [3:0]    ebe;
    rsp_t          e;
    @(negedge CLK);
    eg = 2'b00;
    if (!RST) eg = (REQ_VALID == 2'b11) ? (m_prio ? 2'b10 : 2'b01) : REQ_VALID;
    gi  = eg[1];
    ew  = REQ_WE[gi];
    ea  = '0; ed = '0; ebm = '0;
    ebe = gi ? REQ_BE[7:4] : REQ_BE[3:0];
    if (eg != 2'b00) begin
      ea  = gi ? REQ_ADDR[2*AW-1:AW] : REQ_ADDR[AW-1:0];
      ed  = gi ? REQ_WDATA[63:32] : REQ_WDATA[31:0];
      ebm = ew ? expand(ebe) : 32'h0;
    end
    check("ready1", rdy1, eg);
    check("ready2", rdy2, eg);
    check("sram1", {s1_men, s1_wen, s1_ren, s1_addr, s1_din},
          {|eg, (|eg) & ew, (|eg) & ~ew, ea, ed});
    check("sram2", {s2_men, s2_wen, s2_ren, s2_addr, s2_din},
          {|eg, (|eg) & ew, (|eg) & ~ew, ea, ed});
    check("bm1", s1_bm, ebm);
    check("bm2", s2_bm, ebm);

    ev1 = 2'b00; ev2 = 2'b00; edat1 = '0; edat2 = '0;
    if (!RST && q1.size() > 0 && q1[0].due == cyc) begin
      ev1 = q1[0].id ? 2'b10 : 2'b01; edat1 = q1[0].dat;
    end
    if (!RST && q2.size() > 0 && q2[0].due == cyc) begin
      ev2 = q2[0].id ? 2'b10 : 2'b01; edat2 = q2[0].dat;
    end
    check("rsp_vld1", rspv1, ev1);
    check("rsp_vld2", rspv2, ev2);
    if (ev1 != 2'b00 || RST) check("rsp_dat1", rd1, edat1);
    if (ev2 != 2'b00 || RST) check("rsp_dat2", rd2, edat2);

    obs_rdy = rdy1; obs_rsp1 = rspv1; obs_rsp2 = rspv2; obs_rd1 = rd1;
    obs_bm1 = s1_bm; obs_wen1 = s1_wen;

    if (RST) begin
      q1.delete(); q2.delete(); m_prio = 1'b0;
    end else begin
      if (ev1 != 2'b00) void'(q1.pop_front());
      if (ev2 != 2'b00) void'(q2.pop_front());
      if (eg != 2'b00) begin
        if (ew) begin
          for (int k = 0; k < 4; k++)
            if (ebe[k]) ref_mem[ea][8*k +: 8] = ed[8*k +: 8];
        end else begin
          e.id = gi; e.dat = ref_mem[ea];
          e.due = cyc + 1; q1.push_back(e);
          e.due = cyc + 2; q2.push_back(e);
        end
        m_prio = REQ_LOCK[gi] ? gi : ~gi;
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i] = '0; mem2[i] = '0; ref_mem[i] = '0;
    end
    dout1 = '0; dout2 = '0; dout2_q = '0;
    m_prio = 1'b0;

    // Reset with both requesters valid.
    RST = 1'b1;
    set_req(2'b11, 2'b00, 2'b00, 10'h001, 10'h002, 32'h0, 32'h0, 4'h0, 4'h0);
    repeat (3) cyc_step();
    check("rst_ready", obs_rdy, 2'b00);
    RST = 1'b0;
    cyc_step();
    check("first_contend", obs_rdy, 2'b01);

    // Write then read back with partial byte enables.
    set_req(2'b01, 2'b00, 2'b01, 10'h005, 10'h000, 32'hDEADBEEF, 32'h0, 4'b0101, 4'h0);
    cyc_step();
    check("wr_bm", obs_bm1, 32'h00FF00FF);
    check("wr_wen", obs_wen1, 1'b1);
    set_req(2'b10, 2'b00, 2'b00, 10'h000, 10'h005, 32'h0, 32'h0, 4'h0, 4'h0);
    cyc_step();
    REQ_VALID = 2'b00;
    cyc_step();
    check("rd_rsp", obs_rsp1, 2'b10);
    check("rd_data", obs_rd1, 32'h00AD00EF);

    // Continuous contention, unlocked: strict alternation, responses in grant order.
    for (int i = 0; i < 7; i++) begin
      if (i == 6) REQ_VALID = 2'b00;
      else set_req(2'b11, 2'b00, 2'b00, 10'(i), 10'(i + 8), 32'h0, 32'h0, 4'h0, 4'h0);
      cyc_step();
      if (i < 6) check("fair_grant", obs_rdy, (i % 2 == 1) ? 2'b10 : 2'b01);
      if (i >= 1) check("fair_rsp", obs_rsp1, ((i - 1) % 2 == 1) ? 2'b10 : 2'b01);
    end

    // Lock held on req0; released during its fourth grant.
    for (int i = 0; i < 5; i++) begin
      set_req(2'b11, (i < 3) ? 2'b01 : 2'b00, 2'b00, 10'h003, 10'h004,
              32'h0, 32'h0, 4'h0, 4'h0);
      cyc_step();
      check("lock_grant", obs_rdy, (i < 4) ? 2'b01 : 2'b10);
    end
    REQ_VALID = 2'b00;
    repeat (3) cyc_step();

    // RD_LAT=2 timing, then a reset landing while the read is in flight.
    set_req(2'b01, 2'b00, 2'b00, 10'h005, 10'h000, 32'h0, 32'h0, 4'h0, 4'h0);
    cyc_step();
    REQ_VALID = 2'b00;
    cyc_step();
    check("lat2_early", obs_rsp2, 2'b00);
    cyc_step();
    check("lat2_rsp", obs_rsp2, 2'b01);
    REQ_VALID = 2'b01;
    cyc_step();
    REQ_VALID = 2'b00;
    RST = 1'b1;
    cyc_step();
    RST = 1'b0;
    cyc_step();
    check("rst_drop", obs_rsp2, 2'b00);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      RST = ($urandom_range(59) == 0);
      set_req(2'($urandom()), ($urandom_range(3) == 0) ? 2'($urandom()) : 2'b00,
              2'($urandom()), 10'($urandom_range(15)), 10'($urandom_range(15)),
              $urandom(), $urandom(), 4'($urandom()), 4'($urandom()));
      cyc_step();
    end
    RST = 1'b0;
    REQ_VALID = 2'b00;
    repeat (4) cyc_step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
